// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with next-PC selection
// (stall / ret / call / jump / branch / sequential), a return-address
// stack, and registered HALTED / FAULT terminal states.
// All state advances on the falling edge of clk; reset is asynchronous, active-high.
module pc_unit #(
    parameter int WIDTH       = 8,
    parameter int INC         = 1,
    parameter int HALT_ADDR   = 255,
    parameter int RESET_ADDR  = 0,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             halted,
    output logic             fault,
    output logic [SP_W-1:0]  sp
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    // The stack array is sized to the full pointer range so sp indexes it
    // exactly; entries at or above STACK_DEPTH are never written.
    localparam int STK_N = 1 << SP_W;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [WIDTH-1:0] stack_q [STK_N];
    logic [WIDTH-1:0] stack_d [STK_N];

    logic [WIDTH-1:0] cand;
    logic [SP_W-1:0]  sp_cand;
    logic [SP_W-1:0]  sp_dec;
    logic             do_push;
    logic             do_fault;

    assign sp_dec      = sp_q - SP_W'(1);
    assign pc_next_seq = pc_q + WIDTH'(INC);

    // Next-state selection: priority mux, fault detection and halt check.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        cand     = pc_next_seq;
        sp_cand  = sp_q;
        do_push  = 1'b0;
        do_fault = 1'b0;

        if (state_q == ST_RUN && !stall) begin
            if (ret) begin
                if (sp_q == '0) begin
                    do_fault = 1'b1;
                end else begin
                    cand    = stack_q[sp_dec];
                    sp_cand = sp_dec;
                end
            end else if (call) begin
                if (sp_q == SP_W'(STACK_DEPTH)) begin
                    do_fault = 1'b1;
                end else begin
                    cand    = jump_target;
                    sp_cand = sp_q + SP_W'(1);
                    do_push = 1'b1;
                end
            end else if (jump) begin
                cand = jump_target;
            end else if (branch_taken) begin
                cand = branch_target;
            end

            if (do_fault) begin
                state_d = ST_FAULT;
            end else if (cand == WIDTH'(HALT_ADDR)) begin
                // Halting discards the pc update and any push or pop.
                state_d = ST_HALTED;
            end else begin
                pc_d = cand;
                sp_d = sp_cand;
                if (do_push) begin
                    stack_d[sp_q] = pc_next_seq;
                end
            end
        end
    end

    // Control state register: pc, sp and run state, async reset.
    always_ff @(negedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // flops sample the values computed before this edge.
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= WIDTH'(RESET_ADDR);
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
        end
    end

    // Return-address storage.
    always_ff @(negedge clk) begin
        // NOTE: stack contents are not reset; sp=0 marks every entry invalid,
        // so a reset network here would only cost area.
        stack_q <= stack_d;
    end

    assign pc     = pc_q;
    assign sp     = sp_q;
    assign halted = (state_q == ST_HALTED);
    assign fault  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus a randomized run against a
// queue-based reference model of the program counter.
module tb_pc_unit;

    logic       clk = 1'b1;
    logic       reset;
    logic       stall, branch_taken, jump, call, ret;
    logic [7:0] branch_target, jump_target;
    logic [7:0] pc, pc_next_seq;
    logic       halted, fault;
    logic [2:0] sp;

    // Narrow instance: WIDTH=4, HALT_ADDR=9.
    logic       w_reset;
    logic       w_jump;
    logic [3:0] w_jump_target;
    logic [3:0] w_pc, w_pc_next_seq;
    logic       w_halted, w_fault;
    logic [2:0] w_sp;

    int checks   = 0;
    int failures = 0;

    // Reference model: state 0=run, 1=halted, 2=fault.
    int m_pc;
    int m_state;
    int m_stk[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .ret(ret), .jump_target(jump_target),
        .pc(pc), .pc_next_seq(pc_next_seq), .halted(halted),
        .fault(fault), .sp(sp)
    );

    pc_unit #(.WIDTH(4), .HALT_ADDR(9)) dut_w (
        .clk(clk), .reset(w_reset), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(4'd0),
        .jump(w_jump), .call(1'b0), .ret(1'b0), .jump_target(w_jump_target),
        .pc(w_pc), .pc_next_seq(w_pc_next_seq), .halted(w_halted),
        .fault(w_fault), .sp(w_sp)
    );

    task automatic model_reset();
        m_pc    = 0;
        m_state = 0;
        m_stk.delete();
    endtask

    task automatic model_step(input bit s, input bit br, input int bt,
                              input bit j, input bit c, input bit r, input int jt);
        int  nxt;
        bit  push, pop, flt;
        if (m_state != 0 || s) return;
        nxt = (m_pc + 1) % 256;
        push = 0; pop = 0; flt = 0;
        if (r) begin
            if (m_stk.size() == 0) flt = 1;
            else begin nxt = m_stk[$]; pop = 1; end
        end else if (c) begin
            if (m_stk.size() == 4) flt = 1;
            else begin nxt = jt; push = 1; end
        end else if (j) nxt = jt;
        else if (br) nxt = bt;
        if (flt) m_state = 2;
        else if (nxt == 255) m_state = 1;
        else begin
            if (push) m_stk.push_back((m_pc + 1) % 256);
            if (pop) void'(m_stk.pop_back());
            m_pc = nxt;
        end
    endtask

    // One falling edge with the given controls, then sample 1 time unit later.
    task automatic step(input bit s, input bit br, input int bt,
                        input bit j, input bit c, input bit r, input int jt);
        stall = s; branch_taken = br; branch_target = 8'(bt);
        jump = j; call = c; ret = r; jump_target = 8'(jt);
        @(negedge clk);
        #1;
        model_step(s, br, bt, j, c, r, jt);
        stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called just after a sampled edge; reset pulse stays clear of any edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (pc !== 8'd0 || sp !== 3'd0 || halted !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%0d sp=%0d halted=%b fault=%b, want 0 0 0 0",
                     pc, sp, halted, fault);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 5; i++) begin
            idle();
            checks++;
            if (pc !== 8'(i) || halted !== 1'b0) begin
                failures++;
                $display("FAIL seq_run[%0d]: pc=%0d halted=%b, want %0d 0", i, pc, halted, i);
            end
        end
        checks++;
        if (pc_next_seq !== 8'd6) begin
            failures++;
            $display("FAIL pc_next_seq: got %0d want 6", pc_next_seq);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        step(0, 0, 0, 1, 0, 0, 8'h10);
        step(0, 0, 0, 0, 1, 0, 8'h40);
        checks++;
        if (pc !== 8'h40 || sp !== 3'd1) begin
            failures++;
            $display("FAIL call: pc=%h sp=%0d, want 40 1", pc, sp);
        end
        repeat (3) idle();
        checks++;
        if (pc !== 8'h43) begin
            failures++;
            $display("FAIL call_body: pc=%h want 43", pc);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (pc !== 8'h11 || sp !== 3'd0) begin
            failures++;
            $display("FAIL ret: pc=%h sp=%0d, want 11 0", pc, sp);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0, 8'h40 + 16 * i);
            checks++;
            if (pc !== 8'(8'h40 + 16 * i) || sp !== 3'(i + 1)) begin
                failures++;
                $display("FAIL nested_call[%0d]: pc=%h sp=%0d, want %h %0d",
                         i, pc, sp, 8'h40 + 16 * i, i + 1);
            end
        end
        step(0, 0, 0, 0, 1, 0, 8'h80);
        checks++;
        if (fault !== 1'b1 || pc !== 8'h70 || sp !== 3'd4) begin
            failures++;
            $display("FAIL overflow: fault=%b pc=%h sp=%0d, want 1 70 4", fault, pc, sp);
        end
        step(0, 0, 0, 1, 0, 0, 8'h10);
        step(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (fault !== 1'b1 || pc !== 8'h70 || sp !== 3'd4 || pc_next_seq !== 8'h71) begin
            failures++;
            $display("FAIL fault_frozen: fault=%b pc=%h sp=%0d nseq=%h, want 1 70 4 71",
                     fault, pc, sp, pc_next_seq);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        idle();
        idle();
        step(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (fault !== 1'b1 || pc !== 8'd2 || sp !== 3'd0) begin
            failures++;
            $display("FAIL underflow: fault=%b pc=%0d sp=%0d, want 1 2 0", fault, pc, sp);
        end
        do_reset();
        checks++;
        if (fault !== 1'b0 || pc !== 8'd0) begin
            failures++;
            $display("FAIL fault_clear: fault=%b pc=%0d, want 0 0", fault, pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        step(0, 0, 0, 1, 0, 0, 250);
        repeat (4) idle();
        checks++;
        if (pc !== 8'd254 || halted !== 1'b0) begin
            failures++;
            $display("FAIL pre_halt: pc=%0d halted=%b, want 254 0", pc, halted);
        end
        idle();
        checks++;
        if (halted !== 1'b1 || pc !== 8'd254 || pc_next_seq !== 8'd255) begin
            failures++;
            $display("FAIL seq_halt: halted=%b pc=%0d nseq=%0d, want 1 254 255",
                     halted, pc, pc_next_seq);
        end
        step(0, 0, 0, 1, 0, 0, 8'h33);
        checks++;
        if (halted !== 1'b1 || pc !== 8'd254) begin
            failures++;
            $display("FAIL halt_frozen: halted=%b pc=%0d, want 1 254", halted, pc);
        end
        do_reset();
        step(0, 1, 255, 0, 0, 0, 0);
        checks++;
        if (halted !== 1'b1 || pc !== 8'd0) begin
            failures++;
            $display("FAIL branch_halt: halted=%b pc=%0d, want 1 0", halted, pc);
        end
        do_reset();
        step(0, 0, 0, 0, 1, 0, 255);
        checks++;
        if (halted !== 1'b1 || pc !== 8'd0 || sp !== 3'd0) begin
            failures++;
            $display("FAIL call_halt_discard: halted=%b pc=%0d sp=%0d, want 1 0 0",
                     halted, pc, sp);
        end
    endtask

    task automatic test_priority();
        do_reset();
        idle();
        step(1, 0, 0, 1, 0, 0, 8'h55);
        checks++;
        if (pc !== 8'd1) begin
            failures++;
            $display("FAIL stall_jump: pc=%0d want 1", pc);
        end
        step(1, 0, 0, 0, 0, 1, 0);
        checks++;
        if (fault !== 1'b0 || pc !== 8'd1) begin
            failures++;
            $display("FAIL stall_ret: fault=%b pc=%0d, want 0 1", fault, pc);
        end
        step(0, 1, 8'h30, 1, 0, 0, 8'h20);
        checks++;
        if (pc !== 8'h20) begin
            failures++;
            $display("FAIL jump_over_branch: pc=%h want 20", pc);
        end
        step(0, 0, 0, 0, 1, 1, 8'h60);
        checks++;
        if (fault !== 1'b1 || pc !== 8'h20) begin
            failures++;
            $display("FAIL ret_over_call: fault=%b pc=%h, want 1 20", fault, pc);
        end
    endtask

    task automatic test_wrap();
        w_reset = 1'b0;
        w_jump = 1'b1;
        w_jump_target = 4'd15;
        @(negedge clk);
        #1;
        w_jump = 1'b0;
        checks++;
        if (w_pc !== 4'd15 || w_pc_next_seq !== 4'd0) begin
            failures++;
            $display("FAIL narrow_jump: pc=%0d nseq=%0d, want 15 0", w_pc, w_pc_next_seq);
        end
        @(negedge clk);
        #1;
        checks++;
        if (w_pc !== 4'd0 || w_halted !== 1'b0 || w_fault !== 1'b0 || w_sp !== 3'd0) begin
            failures++;
            $display("FAIL narrow_wrap: pc=%0d halted=%b fault=%b sp=%0d, want 0 0 0 0",
                     w_pc, w_halted, w_fault, w_sp);
        end
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (w_pc !== 4'd8 || w_halted !== 1'b1) begin
            failures++;
            $display("FAIL narrow_halt: pc=%0d halted=%b, want 8 1", w_pc, w_halted);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 0, 0, 0, 1, 0, 8'h90);
        idle();
        @(posedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pc !== 8'd0 || sp !== 3'd0) begin
            failures++;
            $display("FAIL async_reset: pc=%h sp=%0d, want 0 0", pc, sp);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
    endtask

    task automatic test_random();
        int frozen = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 255),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 255));
            checks++;
            if (pc !== 8'(m_pc) || sp !== 3'(m_stk.size()) ||
                halted !== (m_state == 1) || fault !== (m_state == 2) ||
                pc_next_seq !== 8'((m_pc + 1) % 256)) begin
                failures++;
                $display("FAIL random[%0d]: pc=%0d sp=%0d h=%b f=%b nseq=%0d, want %0d %0d %0d %0d %0d",
                         i, pc, sp, halted, fault, pc_next_seq, m_pc, m_stk.size(),
                         m_state == 1, m_state == 2, (m_pc + 1) % 256);
            end
            if (m_state != 0) frozen++;
            if (frozen > 2) begin
                frozen = 0;
                do_reset();
            end
        end
    endtask

    initial begin
        stall = 0; branch_taken = 0; branch_target = 0;
        jump = 0; call = 0; ret = 0; jump_target = 0;
        w_reset = 1'b1; w_jump = 1'b0; w_jump_target = 4'd0;
        model_reset();
        test_reset();
        test_sequential();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_halt();
        test_priority();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
